// File: rtl/butterfly_rad2_pipe.sv
// Pipelined radix-2 complex butterfly (DIT/DIF per sample) with post-scaling,
// round-half-up, saturation and overflow accounting. Five-stage pipeline with a
// global stall driven by the output handshake.
module butterfly_rad2_pipe #(
   parameter int unsigned D_WIDTH   = 14,
   parameter int unsigned W_WIDTH   = 4,
   parameter int unsigned CUT_WIDTH = 4,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        aresetn,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        mode,
   input  logic [CUT_WIDTH-1:0]        cut,
   input  logic signed [D_WIDTH-1:0]   A_R,
   input  logic signed [D_WIDTH-1:0]   A_I,
   input  logic signed [D_WIDTH-1:0]   B_R,
   input  logic signed [D_WIDTH-1:0]   B_I,
   input  logic signed [W_WIDTH-1:0]   W_R,
   input  logic signed [W_WIDTH-1:0]   W_I,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [D_WIDTH-1:0]   C_R,
   output logic signed [D_WIDTH-1:0]   C_I,
   output logic signed [D_WIDTH-1:0]   D_R,
   output logic signed [D_WIDTH-1:0]   D_I,
   output logic                        ovf,
   output logic                        ovf_sticky,
   output logic [CNT_WIDTH-1:0]        ovf_cnt,
   input  logic                        ovf_clr
);

   localparam int unsigned IW   = D_WIDTH + 3;
   localparam int unsigned PW   = IW + W_WIDTH;
   localparam int unsigned RS   = W_WIDTH - 1;
   localparam int unsigned CMAX = IW - 1;
   localparam logic signed [PW-1:0] RND_P  = PW'(2 ** (W_WIDTH - 2));
   localparam logic signed [IW:0]   SAT_HI = (IW + 1)'(2 ** (D_WIDTH - 1) - 1);
   localparam logic signed [IW:0]   SAT_LO = ~SAT_HI;

   // Rounded right shift then clamp; MSB of the result flags a clamp.
   function automatic logic [D_WIDTH:0] scale_sat(input logic signed [IW-1:0] v,
                                                  input int unsigned sh);
      logic signed [IW:0] ext;
      logic signed [IW:0] shr;
      ext = (IW + 1)'(v);
      if (sh == 0) shr = ext;
      else         shr = (ext + $signed((IW + 1)'(1) << (sh - 1))) >>> sh;
      if (shr > SAT_HI)      return {1'b1, 1'b0, {(D_WIDTH - 1){1'b1}}};
      else if (shr < SAT_LO) return {1'b1, 1'b1, {(D_WIDTH - 1){1'b0}}};
      else                   return {1'b0, D_WIDTH'(shr)};
   endfunction

   logic en;

   logic                       s1_v, s1_mode;
   logic [CUT_WIDTH-1:0]       s1_cut;
   logic signed [D_WIDTH-1:0]  s1_ar, s1_ai, s1_br, s1_bi;
   logic signed [W_WIDTH-1:0]  s1_wr, s1_wi;

   logic                       s2_v, s2_mode;
   logic [CUT_WIDTH-1:0]       s2_cut;
   logic signed [W_WIDTH-1:0]  s2_wr, s2_wi;
   logic signed [IW-1:0]       s2_yr, s2_yi, s2_xr, s2_xi;

   logic                       s3_v, s3_mode;
   logic [CUT_WIDTH-1:0]       s3_cut;
   logic signed [IW-1:0]       s3_yr, s3_yi;
   logic signed [PW-1:0]       s3_prr, s3_pii, s3_pri, s3_pir;

   logic                       s4_v;
   logic [CUT_WIDTH-1:0]       s4_cut;
   logic signed [IW-1:0]       s4_cr, s4_ci, s4_dr, s4_di;

   logic signed [IW-1:0]       n2_yr, n2_yi, n2_xr, n2_xi;
   logic signed [PW-1:0]       n3_prr, n3_pii, n3_pri, n3_pir;
   logic signed [PW-1:0]       n4_re, n4_im;
   logic signed [IW-1:0]       n4_mr, n4_mi, n4_cr, n4_ci, n4_dr, n4_di;
   logic [D_WIDTH:0]           n5_cr, n5_ci, n5_dr, n5_di;
   int unsigned                n5_sh;

   // Whole pipeline advances unless the output register is holding an unaccepted sample.
   assign en       = !(out_valid && !out_ready);
   assign in_ready = en;

   // Stage 2 pre-add: DIF forms A+B and A-B; DIT passes A and B through.
   always_comb begin
      n2_yr = IW'(s1_ar);
      n2_yi = IW'(s1_ai);
      n2_xr = IW'(s1_br);
      n2_xi = IW'(s1_bi);
      if (s1_mode) begin
         n2_yr = IW'(s1_ar) + IW'(s1_br);
         n2_yi = IW'(s1_ai) + IW'(s1_bi);
         n2_xr = IW'(s1_ar) - IW'(s1_br);
         n2_xi = IW'(s1_ai) - IW'(s1_bi);
      end
   end

   // Stage 3 partial products of X*W.
   always_comb begin
      n3_prr = PW'(s2_xr) * PW'(s2_wr);
      n3_pii = PW'(s2_xi) * PW'(s2_wi);
      n3_pri = PW'(s2_xr) * PW'(s2_wi);
      n3_pir = PW'(s2_xi) * PW'(s2_wr);
   end

   // Stage 4 product combine, twiddle rounding and post-add.
   always_comb begin
      n4_re = s3_prr - s3_pii;
      n4_im = s3_pri + s3_pir;
      n4_mr = IW'((n4_re + RND_P) >>> RS);
      n4_mi = IW'((n4_im + RND_P) >>> RS);
      n4_cr = s3_yr + n4_mr;
      n4_ci = s3_yi + n4_mi;
      n4_dr = s3_yr - n4_mr;
      n4_di = s3_yi - n4_mi;
      if (s3_mode) begin
         n4_cr = s3_yr;
         n4_ci = s3_yi;
         n4_dr = n4_mr;
         n4_di = n4_mi;
      end
   end

   // Stage 5 output scaling and saturation.
   always_comb begin
      n5_sh = (32'(s4_cut) > CMAX) ? CMAX : 32'(s4_cut);
      n5_cr = scale_sat(s4_cr, n5_sh);
      n5_ci = scale_sat(s4_ci, n5_sh);
      n5_dr = scale_sat(s4_dr, n5_sh);
      n5_di = scale_sat(s4_di, n5_sh);
   end

   // Pipeline registers; every stage holds during a stall.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         s1_v <= 1'b0; s1_mode <= 1'b0; s1_cut <= '0;
         s1_ar <= '0; s1_ai <= '0; s1_br <= '0; s1_bi <= '0;
         s1_wr <= '0; s1_wi <= '0;
         s2_v <= 1'b0; s2_mode <= 1'b0; s2_cut <= '0; s2_wr <= '0; s2_wi <= '0;
         s2_yr <= '0; s2_yi <= '0; s2_xr <= '0; s2_xi <= '0;
         s3_v <= 1'b0; s3_mode <= 1'b0; s3_cut <= '0; s3_yr <= '0; s3_yi <= '0;
         s3_prr <= '0; s3_pii <= '0; s3_pri <= '0; s3_pir <= '0;
         s4_v <= 1'b0; s4_cut <= '0;
         s4_cr <= '0; s4_ci <= '0; s4_dr <= '0; s4_di <= '0;
         out_valid <= 1'b0; ovf <= 1'b0;
         C_R <= '0; C_I <= '0; D_R <= '0; D_I <= '0;
      end else if (en) begin
         s1_v <= in_valid; s1_mode <= mode; s1_cut <= cut;
         s1_ar <= A_R; s1_ai <= A_I; s1_br <= B_R; s1_bi <= B_I;
         s1_wr <= W_R; s1_wi <= W_I;
         s2_v <= s1_v; s2_mode <= s1_mode; s2_cut <= s1_cut; s2_wr <= s1_wr; s2_wi <= s1_wi;
         s2_yr <= n2_yr; s2_yi <= n2_yi; s2_xr <= n2_xr; s2_xi <= n2_xi;
         s3_v <= s2_v; s3_mode <= s2_mode; s3_cut <= s2_cut; s3_yr <= s2_yr; s3_yi <= s2_yi;
         s3_prr <= n3_prr; s3_pii <= n3_pii; s3_pri <= n3_pri; s3_pir <= n3_pir;
         s4_v <= s3_v; s4_cut <= s3_cut;
         s4_cr <= n4_cr; s4_ci <= n4_ci; s4_dr <= n4_dr; s4_di <= n4_di;
         out_valid <= s4_v;
         ovf <= s4_v && (n5_cr[D_WIDTH] || n5_ci[D_WIDTH] || n5_dr[D_WIDTH] || n5_di[D_WIDTH]);
         C_R <= n5_cr[D_WIDTH-1:0];
         C_I <= n5_ci[D_WIDTH-1:0];
         D_R <= n5_dr[D_WIDTH-1:0];
         D_I <= n5_di[D_WIDTH-1:0];
      end
   end

   // Overflow accounting on output transfers; a clear takes effect before a coincident event.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         ovf_sticky <= 1'b0;
         ovf_cnt    <= '0;
      end else if (ovf_clr) begin
         ovf_sticky <= out_valid && out_ready && ovf;
         ovf_cnt    <= (out_valid && out_ready && ovf) ? CNT_WIDTH'(1) : '0;
      end else if (out_valid && out_ready && ovf) begin
         ovf_sticky <= 1'b1;
         if (ovf_cnt != '1) ovf_cnt <= ovf_cnt + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_butterfly_rad2_pipe.sv
// Self-checking bench for butterfly_rad2_pipe: directed vector table, random
// stream with backpressure, overflow clear corner case and mid-flight reset.
module tb_butterfly_rad2_pipe;

   localparam int unsigned DW = 14;
   localparam int unsigned WW = 4;
   localparam int unsigned CW = 4;
   localparam int unsigned NW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic aresetn, in_valid, in_ready, mode, out_valid, out_ready;
   logic ovf, ovf_sticky, ovf_clr;
   logic [CW-1:0] cut;
   logic signed [DW-1:0] a_r, a_i, b_r, b_i, c_r, c_i, d_r, d_i;
   logic signed [WW-1:0] w_r, w_i;
   logic [NW-1:0] ovf_cnt;

   butterfly_rad2_pipe #(.D_WIDTH(DW), .W_WIDTH(WW), .CUT_WIDTH(CW), .CNT_WIDTH(NW)) dut (
      .clk(clk), .aresetn(aresetn),
      .in_valid(in_valid), .in_ready(in_ready), .mode(mode), .cut(cut),
      .A_R(a_r), .A_I(a_i), .B_R(b_r), .B_I(b_i), .W_R(w_r), .W_I(w_i),
      .out_valid(out_valid), .out_ready(out_ready),
      .C_R(c_r), .C_I(c_i), .D_R(d_r), .D_I(d_i),
      .ovf(ovf), .ovf_sticky(ovf_sticky), .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
   );

   typedef struct {
      int cr, ci, dr, di;
      bit ovf;
      int ecnt;
   } sb_t;

   typedef struct {
      bit    md;
      int    ct, ar, ai, br, bi, wr, wi;
      int    cr, ci, dr, di;
      bit    ovf;
      int    cnt_after;
      string name;
   } vec_t;

   sb_t  q[$];
   sb_t  cur_exp;
   vec_t vecs[7];
   int   n_cmp = 0;
   int   n_err = 0;
   int   ecnt  = 0;
   bit   accepted;
   bit   clr_on_ovf = 1'b0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic longint rnd_w(input longint p);
      return (p + (longint'(1) <<< (WW - 2))) >>> (WW - 1);
   endfunction

   function automatic longint scl(input longint v, input int c);
      int s;
      s = (c > int'(DW + 2)) ? int'(DW + 2) : c;
      if (s == 0) return v;
      return (v + (longint'(1) <<< (s - 1))) >>> s;
   endfunction

   function automatic longint clampv(input longint v);
      if (v > 8191)  return 8191;
      if (v < -8192) return -8192;
      return v;
   endfunction

   function automatic sb_t model(input bit md, input int ct, input int ar, input int ai,
                                 input int br, input int bi, input int wr, input int wi);
      longint cr, ci, dr, di, pr, pi, xr, xi, v[4];
      sb_t r;
      if (!md) begin
         pr = rnd_w(longint'(br) * wr - longint'(bi) * wi);
         pi = rnd_w(longint'(br) * wi + longint'(bi) * wr);
         cr = ar + pr; ci = ai + pi; dr = ar - pr; di = ai - pi;
      end else begin
         cr = ar + br; ci = ai + bi;
         xr = ar - br; xi = ai - bi;
         dr = rnd_w(xr * wr - xi * wi);
         di = rnd_w(xr * wi + xi * wr);
      end
      v[0] = scl(cr, ct); v[1] = scl(ci, ct); v[2] = scl(dr, ct); v[3] = scl(di, ct);
      r.ovf = 1'b0;
      for (int k = 0; k < 4; k++) if (clampv(v[k]) != v[k]) r.ovf = 1'b1;
      r.cr = int'(clampv(v[0])); r.ci = int'(clampv(v[1]));
      r.dr = int'(clampv(v[2])); r.di = int'(clampv(v[3]));
      r.ecnt = 0;
      return r;
   endfunction

   task automatic set_in(input bit md, input int ct, input int ar, input int ai,
                         input int br, input int bi, input int wr, input int wi);
      mode = md; cut = CW'(ct);
      a_r = DW'(ar); a_i = DW'(ai); b_r = DW'(br); b_i = DW'(bi);
      w_r = WW'(wr); w_i = WW'(wi);
      cur_exp = model(md, ct, ar, ai, br, bi, wr, wi);
   endtask

   // One clock: sample at the falling edge, score outputs, log the accepted input.
   task automatic step();
      sb_t e;
      bit  hit;
      hit = 1'b0;
      @(negedge clk);
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      accepted = in_valid && in_ready;
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("out_without_input", out_valid, 0);
         end else begin
            e = q.pop_front();
            chk("C_R", c_r, e.cr);
            chk("C_I", c_i, e.ci);
            chk("D_R", d_r, e.dr);
            chk("D_I", d_i, e.di);
            chk("ovf", ovf, e.ovf);
            chk("latency", ecnt - e.ecnt, 5);
            if (clr_on_ovf && ovf) begin
               ovf_clr = 1'b1;
               hit     = 1'b1;
            end
         end
      end
      if (accepted) begin
         e      = cur_exp;
         e.ecnt = ecnt;
         q.push_back(e);
      end
      if (in_ready) ecnt++;
      @(posedge clk);
      #1;
      if (hit) ovf_clr = 1'b0;
   endtask

   task automatic send();
      in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         step();
         if (accepted) break;
      end
      chk("send_accepted", accepted, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 200 && q.size() > 0; i++) step();
      chk("drain_left", q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{0, 0, 100, 0, 200, 0, -8, 0, -100, 0, 300, 0, 0, 0, "dit_minus_one"};
      vecs[1] = '{0, 0, 0, 0, 200, 50, 0, -8, 50, -200, -50, 200, 0, 0, "dit_minus_j"};
      vecs[2] = '{1, 0, 8191, 0, 8191, 0, -8, 0, 8191, 0, 0, 0, 1, 1, "dif_sat_cut0"};
      vecs[3] = '{1, 1, 8191, 0, 8191, 0, -8, 0, 8191, 0, 0, 0, 0, 1, "dif_nosat_cut1"};
      vecs[4] = '{1, 1, 2, -2, 1, -1, -8, 0, 2, -1, 0, 1, 0, 1, "dif_round"};
      vecs[5] = '{1, 0, -8192, -8192, -8192, 8191, 0, 0, -8192, -1, 0, 0, 1, 2, "dif_neg_sat"};
      vecs[6] = '{0, 13, 8191, -8192, 0, 0, 0, 0, 1, -1, 1, -1, 0, 2, "dit_cut13"};

      aresetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_ovf_cnt", ovf_cnt, 0);
      chk("rst_sticky", ovf_sticky, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_C_R", c_r, 0);
      @(negedge clk) aresetn = 1'b1;
      @(posedge clk);
      #1;

      // Directed vectors, one at a time with full drain.
      foreach (vecs[i]) begin
         set_in(vecs[i].md, vecs[i].ct, vecs[i].ar, vecs[i].ai, vecs[i].br, vecs[i].bi,
                vecs[i].wr, vecs[i].wi);
         cur_exp.cr = vecs[i].cr; cur_exp.ci = vecs[i].ci;
         cur_exp.dr = vecs[i].dr; cur_exp.di = vecs[i].di;
         cur_exp.ovf = vecs[i].ovf;
         send();
         drain();
         chk({vecs[i].name, "_cnt"}, ovf_cnt, vecs[i].cnt_after);
         chk({vecs[i].name, "_sticky"}, ovf_sticky, vecs[i].cnt_after != 0);
      end

      // Random stream with random backpressure and input gaps.
      begin
         int sent = 0;
         for (int g = 0; g < 2000 && sent < 20; g++) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
               set_in(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192,
                      int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192,
                      int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8);
               in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            step();
            if (accepted) begin
               sent++;
               in_valid = 1'b0;
            end
         end
         chk("stream_sent", sent, 20);
         drain();
      end

      // Clear coincident with a saturating output transfer.
      chk("pre_clr_cnt_nonzero", ovf_cnt != 0, 1);
      clr_on_ovf = 1'b1;
      set_in(1, 0, 8191, 0, 8191, 0, -8, 0);
      send();
      drain();
      clr_on_ovf = 1'b0;
      chk("clr_coinc_cnt", ovf_cnt, 1);
      chk("clr_coinc_sticky", ovf_sticky, 1);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      chk("clr_cnt", ovf_cnt, 0);
      chk("clr_sticky", ovf_sticky, 0);

      // Mid-flight reset: three samples in flight, oldest stalled at the output.
      set_in(1, 0, 8191, 0, 8191, 0, -8, 0);
      send();
      drain();
      chk("pre_rst_cnt", ovf_cnt, 1);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_in(0, 0, 10 * i, 1, 2, 3, 3, -2);
         send();
      end
      for (int i = 0; i < 10 && !out_valid; i++) step();
      chk("pre_rst_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      #2 aresetn = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_ovf_cnt", ovf_cnt, 0);
      chk("midrst_sticky", ovf_sticky, 0);
      chk("midrst_in_ready", in_ready, 1);
      q.delete();
      @(negedge clk) aresetn = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      set_in(0, 2, 1234, -567, -890, 321, 5, -3);
      send();
      set_in(1, 1, -4000, 3000, 2500, -1500, -7, 6);
      send();
      drain();
      in_valid = 1'b0;
      repeat (10) step();
      chk("final_queue", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
